// File: rtl/uart_pkg.sv
// uart_pkg: ASCII constants and reporter FSM states shared by the UART hex reporter.
package uart_pkg;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: one hex nibble to its uppercase ASCII digit.
module nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb ascii = (nibble <= 4'd9) ? ASCII_0 + {4'h0, nibble} : ASCII_A + {4'h0, nibble} - 8'd10;
endmodule

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: sends an accepted word as uppercase ASCII hex, MSB first,
// optionally followed by CR LF, one byte per transmitter start/finish handshake.
module uart_hex_reporter
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter bit TERMINATE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_finish,
  output logic                  busy
);
  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int IW = $clog2(NIBBLES + 2);
  localparam logic [IW-1:0] LAST   = IW'(TERMINATE ? NIBBLES + 1 : NIBBLES - 1);
  localparam logic [IW-1:0] DIGITS = IW'(NIBBLES);
  state_t state, state_n;
  logic [IW-1:0] index, index_n;
  logic [WORD_WIDTH-1:0] word_q, word_n;
  logic [7:0] digit;
  // The word register shifts left per digit, so the current nibble is always on top.
  nibble_to_ascii u_digit (.nibble(word_q[WORD_WIDTH-1 -: 4]), .ascii(digit));
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      index  <= '0;
      word_q <= '0;
    end else begin
      state  <= state_n;
      index  <= index_n;
      word_q <= word_n;
    end
  end
  always_comb begin
    state_n = state;
    index_n = index;
    word_n  = word_q;
    case (state)
      IDLE: if (word_valid) begin
        state_n = LOAD;
        index_n = '0;
        word_n  = word_in;
      end
      LOAD: state_n = WAIT;
      WAIT: if (tx_finish) begin
        state_n = (index == LAST) ? IDLE : LOAD;
        if (index != LAST) begin
          index_n = index + IW'(1);
          word_n  = word_q << 4;
        end
      end
      default: state_n = IDLE;
    endcase
    word_ready = reset_n && state == IDLE;
    busy       = state != IDLE;
    tx_start   = state == LOAD;
    tx_data    = (state == IDLE) ? 8'h00 : (index < DIGITS) ? digit : (index == DIGITS) ? ASCII_CR : ASCII_LF;
  end
endmodule
